// File: rtl/shared_buff_pkg.sv
// Shared types and width helpers for the shared-buffer queue manager.
package shared_buff_pkg;

  typedef enum logic {ST_INIT, ST_RUN} qctrl_state_e;

  function automatic int calc_aw(input int d);
    return $clog2(d);
  endfunction

  function automatic int calc_qw(input int q);
    return (q > 1) ? $clog2(q) : 1;
  endfunction

  function automatic int calc_cw(input int d);
    return $clog2(d + 1);
  endfunction

endpackage

// File: rtl/shared_buff_link_ram.sv
// Next-pointer link store: D x AW flops, two combinational read ports and two write ports.
module shared_buff_link_ram #(
  parameter int D  = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          we0_i,
  input  logic [AW-1:0] waddr0_i,
  input  logic [AW-1:0] wdata0_i,
  input  logic          we1_i,
  input  logic [AW-1:0] waddr1_i,
  input  logic [AW-1:0] wdata1_i,
  input  logic [AW-1:0] raddr0_i,
  output logic [AW-1:0] rdata0_o,
  input  logic [AW-1:0] raddr1_i,
  output logic [AW-1:0] rdata1_o
);

  logic [AW-1:0] mem_q [D];
  logic [AW-1:0] mem_d [D];

  // The controller guarantees the two write addresses never collide in one cycle.
  always_comb begin
    mem_d = mem_q;
    if (we0_i) mem_d[waddr0_i] = wdata0_i;
    if (we1_i) mem_d[waddr1_i] = wdata1_i;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata0_o = mem_q[raddr0_i];
  assign rdata1_o = mem_q[raddr1_i];

endmodule

// File: rtl/shared_buff_qlist_ctrl.sv
// Queue manager for the shared buffer: Q linked-list queues plus a free list over D slots.
module shared_buff_qlist_ctrl
  import shared_buff_pkg::*;
#(
  parameter int D     = 8,
  parameter int Q     = 4,
  parameter int MAX_Q = D,
  parameter int AW    = calc_aw(D),
  parameter int QW    = calc_qw(Q),
  parameter int CW    = calc_cw(D)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            init_done_o,
  input  logic            push_i,
  input  logic [QW-1:0]   push_qid_i,
  output logic            push_ready_o,
  output logic [AW-1:0]   push_slot_o,
  input  logic            pop_i,
  input  logic [QW-1:0]   pop_qid_i,
  output logic [AW-1:0]   pop_slot_o,
  output logic [Q-1:0]    q_valid_o,
  output logic [Q*CW-1:0] q_cnt_o,
  output logic [CW-1:0]   free_cnt_o,
  output logic            err_o
);

  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_Q);
  localparam logic [CW-1:0] CNT_FULL = CW'(D);
  localparam logic [AW-1:0] IDX_LAST = AW'(D - 1);
  localparam int            SW       = CW + QW + 1;

  qctrl_state_e  state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW-1:0] free_head_q, free_head_d;
  logic [AW-1:0] free_tail_q, free_tail_d;
  logic [CW-1:0] free_cnt_q, free_cnt_d;
  logic [AW-1:0] head_q [Q];
  logic [AW-1:0] head_d [Q];
  logic [AW-1:0] tail_q [Q];
  logic [AW-1:0] tail_d [Q];
  logic [CW-1:0] cnt_q  [Q];
  logic [CW-1:0] cnt_d  [Q];
  logic          err_q, err_d;

  logic          run;
  logic          push_acc, pop_acc, same_q_single;
  logic          push_here, pop_here;
  logic [CW-1:0] push_cnt, pop_cnt;
  logic [AW-1:0] next_free, next_pop;
  logic          fl_we, q_we;
  logic [AW-1:0] fl_waddr, fl_wdata, q_waddr, q_wdata;
  logic [SW-1:0] occ_sum;

  assign run           = (state_q == ST_RUN);
  assign push_cnt      = cnt_q[push_qid_i];
  assign pop_cnt       = cnt_q[pop_qid_i];
  assign push_ready_o  = run && (free_cnt_q != '0) && (push_cnt < CNT_MAX);
  assign push_acc      = push_i && push_ready_o;
  assign pop_acc       = pop_i && run && (pop_cnt != '0);
  assign same_q_single = push_acc && pop_acc && (push_qid_i == pop_qid_i) && (pop_cnt == CNT_ONE);
  assign push_slot_o   = free_head_q;
  assign pop_slot_o    = head_q[pop_qid_i];
  assign free_cnt_o    = free_cnt_q;
  assign err_o         = err_q;
  assign init_done_o   = run;

  // Port 0 builds the free chain during INIT, then appends popped slots to the free tail.
  // It is skipped when the free list is (or is about to become) empty: free_tail is stale then.
  always_comb begin
    fl_we    = 1'b0;
    fl_waddr = free_tail_q;
    fl_wdata = pop_slot_o;
    if (!run) begin
      fl_we    = 1'b1;
      fl_waddr = idx_q;
      fl_wdata = idx_q + AW'(1);
    end else if (pop_acc && (free_cnt_q != '0) && !(push_acc && (free_cnt_q == CNT_ONE))) begin
      fl_we = 1'b1;
    end
    q_we    = push_acc && (push_cnt != '0) && !same_q_single;
    q_waddr = tail_q[push_qid_i];
    q_wdata = free_head_q;
  end

  shared_buff_link_ram #(.D(D), .AW(AW)) u_link (
    .clk      (clk),
    .we0_i    (fl_we),
    .waddr0_i (fl_waddr),
    .wdata0_i (fl_wdata),
    .we1_i    (q_we),
    .waddr1_i (q_waddr),
    .wdata1_i (q_wdata),
    .raddr0_i (free_head_q),
    .rdata0_o (next_free),
    .raddr1_i (pop_slot_o),
    .rdata1_o (next_pop)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    free_head_d = free_head_q;
    free_tail_d = free_tail_q;
    free_cnt_d  = free_cnt_q;
    head_d      = head_q;
    tail_d      = tail_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    push_here   = 1'b0;
    pop_here    = 1'b0;
    if (!run) begin
      idx_d = idx_q + AW'(1);
      if (idx_q == IDX_LAST) begin
        state_d     = ST_RUN;
        free_head_d = '0;
        free_tail_d = IDX_LAST;
        free_cnt_d  = CNT_FULL;
      end
    end else begin
      if ((push_i && !push_ready_o) || (pop_i && (pop_cnt == '0))) err_d = 1'b1;

      // A freed slot lands on an empty (or just-emptied) free list as its sole entry.
      if (push_acc && pop_acc) begin
        if (free_cnt_q == CNT_ONE) begin
          free_head_d = pop_slot_o;
          free_tail_d = pop_slot_o;
        end else begin
          free_head_d = next_free;
          free_tail_d = pop_slot_o;
        end
      end else if (push_acc) begin
        free_head_d = next_free;
        free_cnt_d  = free_cnt_q - CNT_ONE;
      end else if (pop_acc) begin
        if (free_cnt_q == '0) free_head_d = pop_slot_o;
        free_tail_d = pop_slot_o;
        free_cnt_d  = free_cnt_q + CNT_ONE;
      end

      for (int qi = 0; qi < Q; qi++) begin
        push_here = push_acc && (push_qid_i == QW'(qi));
        pop_here  = pop_acc && (pop_qid_i == QW'(qi));
        if (push_here && pop_here) begin
          head_d[qi] = (cnt_q[qi] == CNT_ONE) ? free_head_q : next_pop;
          tail_d[qi] = free_head_q;
        end else if (push_here) begin
          if (cnt_q[qi] == '0) head_d[qi] = free_head_q;
          tail_d[qi] = free_head_q;
          cnt_d[qi]  = cnt_q[qi] + CNT_ONE;
        end else if (pop_here) begin
          head_d[qi] = next_pop;
          cnt_d[qi]  = cnt_q[qi] - CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      idx_q       <= '0;
      free_head_q <= '0;
      free_tail_q <= '0;
      free_cnt_q  <= '0;
      err_q       <= 1'b0;
      for (int qi = 0; qi < Q; qi++) begin
        head_q[qi] <= '0;
        tail_q[qi] <= '0;
        cnt_q[qi]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      free_head_q <= free_head_d;
      free_tail_q <= free_tail_d;
      free_cnt_q  <= free_cnt_d;
      err_q       <= err_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    occ_sum = SW'(free_cnt_q);
    for (int qi = 0; qi < Q; qi++) begin
      q_valid_o[qi]          = (cnt_q[qi] != '0);
      q_cnt_o[qi*CW +: CW]   = cnt_q[qi];
      occ_sum                = occ_sum + SW'(cnt_q[qi]);
    end
  end

  // Every slot is always either on the free list or in exactly one queue.
  always_ff @(posedge clk) begin
    if (!rst && run) assert (occ_sum == SW'(D));
  end

endmodule

// File: tb/tb_shared_buff_qlist_ctrl.sv
// Bench for shared_buff_qlist_ctrl: two instances (cap 8 and cap 2) share stimulus and are
// compared against a queue-of-slots reference model.
module tb_shared_buff_qlist_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pushI = 1'b0;
  logic [1:0]  pushQid = '0;
  logic        popI = 1'b0;
  logic [1:0]  popQid = '0;

  logic        initDone [2];
  logic        pushReady [2];
  logic [2:0]  pushSlot [2];
  logic [2:0]  popSlot [2];
  logic [3:0]  qValid [2];
  logic [15:0] qCnt [2];
  logic [3:0]  freeCnt [2];
  logic        errO [2];

  int total = 0;
  int bad   = 0;

  // Reference model: per instance, four queues of slot ids and a free list of slot ids.
  int mq [8][$];
  int mFree [2][$];
  bit mRun [2] = '{1'b0, 1'b0};
  int mInit [2] = '{8, 8};
  bit mErr [2] = '{1'b0, 1'b0};
  int caps [2] = '{8, 2};

  always #5 clk = ~clk;

  shared_buff_qlist_ctrl #(.D(8), .Q(4), .MAX_Q(8)) dut (
    .clk(clk), .rst(rst), .init_done_o(initDone[0]),
    .push_i(pushI), .push_qid_i(pushQid), .push_ready_o(pushReady[0]), .push_slot_o(pushSlot[0]),
    .pop_i(popI), .pop_qid_i(popQid), .pop_slot_o(popSlot[0]),
    .q_valid_o(qValid[0]), .q_cnt_o(qCnt[0]), .free_cnt_o(freeCnt[0]), .err_o(errO[0])
  );

  shared_buff_qlist_ctrl #(.D(8), .Q(4), .MAX_Q(2)) dutCap (
    .clk(clk), .rst(rst), .init_done_o(initDone[1]),
    .push_i(pushI), .push_qid_i(pushQid), .push_ready_o(pushReady[1]), .push_slot_o(pushSlot[1]),
    .pop_i(popI), .pop_qid_i(popQid), .pop_slot_o(popSlot[1]),
    .q_valid_o(qValid[1]), .q_cnt_o(qCnt[1]), .free_cnt_o(freeCnt[1]), .err_o(errO[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the request seen at that edge.
  task automatic modelStep(input int k, input bit r, input bit p, input int pq, input bit o, input int oq);
    int s, h;
    bit pr, pv;
    s = 0;
    h = 0;
    if (r) begin
      for (int q = 0; q < 4; q++) mq[k*4+q].delete();
      mFree[k].delete();
      mRun[k]  = 1'b0;
      mInit[k] = 8;
      mErr[k]  = 1'b0;
    end else if (!mRun[k]) begin
      mInit[k]--;
      if (mInit[k] == 0) begin
        mRun[k] = 1'b1;
        for (int i = 0; i < 8; i++) mFree[k].push_back(i);
      end
    end else begin
      pr = (mFree[k].size() > 0) && (mq[k*4+pq].size() < caps[k]);
      pv = (mq[k*4+oq].size() > 0);
      if ((p && !pr) || (o && !pv)) mErr[k] = 1'b1;
      if (p && pr) s = mFree[k].pop_front();
      if (o && pv) h = mq[k*4+oq].pop_front();
      if (p && pr) mq[k*4+pq].push_back(s);
      if (o && pv) mFree[k].push_back(h);
    end
  endtask

  task automatic checkComb(input int pq, input int oq);
    bit pr;
    for (int k = 0; k < 2; k++) begin
      pr = mRun[k] && (mFree[k].size() > 0) && (mq[k*4+pq].size() < caps[k]);
      chk($sformatf("push_ready%0d", k), pushReady[k], pr);
      if (mRun[k] && mFree[k].size() > 0)
        chk($sformatf("push_slot%0d", k), pushSlot[k], mFree[k][0]);
      if (mRun[k] && mq[k*4+oq].size() > 0)
        chk($sformatf("pop_slot%0d_q%0d", k, oq), popSlot[k], mq[k*4+oq][0]);
    end
  endtask

  task automatic checkOutput();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("init_done%0d", k), initDone[k], mRun[k]);
      chk($sformatf("free_cnt%0d", k), freeCnt[k], mFree[k].size());
      chk($sformatf("err%0d", k), errO[k], mErr[k]);
      for (int q = 0; q < 4; q++) begin
        chk($sformatf("q_cnt%0d_q%0d", k, q), qCnt[k][q*4 +: 4], mq[k*4+q].size());
        chk($sformatf("q_valid%0d_q%0d", k, q), qValid[k][q], mq[k*4+q].size() > 0);
      end
    end
  endtask

  // Drive one cycle of requests, check the combinational outputs, then the registered state.
  task automatic applyStimulus(input bit p, input int pq, input bit o, input int oq);
    bit r;
    pushI   = p;
    pushQid = 2'(pq);
    popI    = o;
    popQid  = 2'(oq);
    #1;
    checkComb(pq, oq);
    r = rst;
    @(posedge clk);
    for (int k = 0; k < 2; k++) modelStep(k, r, p, pq, o, oq);
    #1;
    checkOutput();
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0);
    rst = 1'b0;
  endtask

  task automatic waitInit();
    int cycles;
    cycles = 0;
    do begin
      applyStimulus(0, 0, 0, 0);
      cycles++;
    end while (!initDone[0] && cycles < 20);
    chk("init_latency", cycles, 8);
  endtask

  // Directed scenarios first, then a random soak with the occupancy-sum check.
  initial begin
    int sum;
    $display("[TB] start");
    doReset();
    waitInit();
    chk("free_after_init", freeCnt[0], 8);
    chk("push_slot_after_init", pushSlot[0], 0);

    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0);
    chk("q0_drained_valid", qValid[0][0], 0);
    chk("q0_drained_free", freeCnt[0], 8);

    doReset();
    waitInit();
    applyStimulus(1, 1, 0, 1);
    applyStimulus(1, 1, 1, 1);
    chk("q1_cnt_after_pushpop", qCnt[0][7:4], 1);
    applyStimulus(0, 0, 0, 1);
    chk("q1_head_slot", popSlot[0], 1);

    for (int i = 0; i < 7; i++) applyStimulus(1, 0, 0, 0);
    chk("full_free_cnt", freeCnt[0], 0);
    applyStimulus(1, 0, 0, 0);
    chk("full_push_err", errO[0], 1);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(1, 2, 1, 0);
    chk("last_slot_pushpop_free", freeCnt[0], 1);
    applyStimulus(0, 0, 0, 0);

    doReset();
    waitInit();
    for (int i = 0; i < 3; i++) applyStimulus(1, 2, 0, 0);
    pushQid = 2'd3;
    #1;
    chk("cap_q3_ready", pushReady[1], 1);
    applyStimulus(0, 0, 1, 3);
    chk("empty_pop_err", errO[1], 1);
    for (int i = 0; i < 2; i++) applyStimulus(1, 3, 0, 0);
    chk("in_use_before_reset", freeCnt[0], 3);
    doReset();
    chk("reset_free_cnt", freeCnt[0], 0);
    waitInit();

    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3));
      sum = int'(freeCnt[0]);
      for (int q = 0; q < 4; q++) sum += int'(qCnt[0][q*4 +: 4]);
      chk("sum_invariant", sum, 8);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
